// File: rtl/alpaca_ospfb_constants_pkg.sv
// Shared OSPFB constants, the frame-sink state encoding and the error-counter helper.
// OSPFB_SINK_ERRCNT_EN (in the sink top) is the only user of errcnt_next.
package alpaca_ospfb_constants_pkg;

  localparam int WIDTH           = 16;
  localparam int FFT_LEN         = 2048;
  localparam int SINK_ERRCNT_WID = 16;

  typedef enum logic [1:0] {IDLE, SYNC, RUN} sink_state_t;

  // A clear in the same cycle as an event leaves a count of one.
  function automatic logic [SINK_ERRCNT_WID-1:0] errcnt_next(
    input logic [SINK_ERRCNT_WID-1:0] cur,
    input logic                       inc,
    input logic                       clr
  );
    logic [SINK_ERRCNT_WID-1:0] base;
    base = clr ? '0 : cur;
    if (inc && (base != '1)) return base + SINK_ERRCNT_WID'(1);
    return base;
  endfunction

endpackage

// File: rtl/ospfb_sink_frame_ram.sv
// Simple dual-port capture buffer: one write port, registered read-first read port.
module ospfb_sink_frame_ram #(
  parameter int    DATA_WID = 32,
  parameter int    DEPTH    = 2048,
  parameter string RAM_TYPE = "auto"
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     wr_en,
  input  logic [$clog2(DEPTH)-1:0] wr_addr,
  input  logic [DATA_WID-1:0]      wr_data,
  input  logic [$clog2(DEPTH)-1:0] rd_addr,
  output logic [DATA_WID-1:0]      rd_data
);

  if (RAM_TYPE == "auto") begin : g_auto
    logic [DATA_WID-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
      if (wr_en) mem[wr_addr] <= wr_data;
    end

    always_ff @(posedge clk) begin
      if (rst) rd_data <= '0;
      else     rd_data <= mem[rd_addr];
    end
  end else begin : g_hint
    (* ram_style = RAM_TYPE *) logic [DATA_WID-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
      if (wr_en) mem[wr_addr] <= wr_data;
    end

    always_ff @(posedge clk) begin
      if (rst) rd_data <= '0;
      else     rd_data <= mem[rd_addr];
    end
  end

endmodule

// File: rtl/ospfb_frame_sink.sv
// OSPFB channelised-stream sink: frame alignment, framing checks, good-frame count, one-frame capture.
// Define OSPFB_SINK_ERRCNT_EN to add saturating per-error event counters.
module ospfb_frame_sink #(
  parameter int    WIDTH         = alpaca_ospfb_constants_pkg::WIDTH,
  parameter int    FFT_LEN       = alpaca_ospfb_constants_pkg::FFT_LEN,
  parameter int    TUSER_WID     = 8,
  parameter int    FRAME_CNT_WID = 32,
  parameter string RAM_TYPE      = "auto"
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       en,
  input  logic [2*WIDTH-1:0]         s_axis_tdata,
  input  logic [TUSER_WID-1:0]       s_axis_tuser,
  input  logic                       s_axis_tvalid,
  input  logic                       s_axis_tlast,
  output logic                       s_axis_tready,
  output logic                       synced,
  output logic [FRAME_CNT_WID-1:0]   frame_count,
  output logic                       err_tlast_unexpected,
  output logic                       err_tlast_missing,
  output logic                       err_tuser_mismatch,
  input  logic                       err_clear,
  input  logic                       capture_req,
  output logic                       capture_busy,
  output logic                       capture_done,
  input  logic [$clog2(FFT_LEN)-1:0] rd_addr,
  output logic [2*WIDTH-1:0]         rd_data
`ifdef OSPFB_SINK_ERRCNT_EN
  ,
  output logic [alpaca_ospfb_constants_pkg::SINK_ERRCNT_WID-1:0] cnt_tlast_unexpected,
  output logic [alpaca_ospfb_constants_pkg::SINK_ERRCNT_WID-1:0] cnt_tlast_missing,
  output logic [alpaca_ospfb_constants_pkg::SINK_ERRCNT_WID-1:0] cnt_tuser_mismatch
`endif
);
  import alpaca_ospfb_constants_pkg::*;

  localparam int BIN_WID = $clog2(FFT_LEN);

  sink_state_t        state, state_nxt;
  logic [BIN_WID-1:0] bin;
  logic               frame_err;
  logic               cap_active;
  logic               beat, run_beat, last_bin, frame_end;
  logic               ev_tuser, ev_missing, ev_unexp, frame_good;
  logic               cap_we;

  assign beat       = s_axis_tvalid & s_axis_tready;
  assign run_beat   = beat & en & (state == RUN);
  assign last_bin   = (bin == BIN_WID'(FFT_LEN - 1));
  assign frame_end  = last_bin | s_axis_tlast;
  assign ev_tuser   = run_beat & (s_axis_tuser != TUSER_WID'(bin));
  assign ev_missing = run_beat & last_bin & ~s_axis_tlast;
  assign ev_unexp   = run_beat & ~last_bin & s_axis_tlast;
  assign frame_good = run_beat & last_bin & s_axis_tlast & ~frame_err & ~ev_tuser;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (!en) begin
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE:    state_nxt = SYNC;
        SYNC:    if (beat && s_axis_tlast) state_nxt = RUN;
        RUN:     if (ev_missing) state_nxt = SYNC;
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_comb begin
    s_axis_tready = (state != IDLE);
    synced        = (state == RUN);
  end

  // Bin and per-frame error tracking restart whenever the sink is not mid-frame in RUN.
  always_ff @(posedge clk) begin
    if (rst) begin
      bin         <= '0;
      frame_err   <= 1'b0;
      frame_count <= '0;
    end else begin
      if (state != RUN || !en) begin
        bin       <= '0;
        frame_err <= 1'b0;
      end else if (run_beat) begin
        if (frame_end) begin
          bin       <= '0;
          frame_err <= 1'b0;
        end else begin
          bin       <= bin + BIN_WID'(1);
          frame_err <= frame_err | ev_tuser;
        end
      end
      if (frame_good) frame_count <= frame_count + FRAME_CNT_WID'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      err_tlast_unexpected <= 1'b0;
      err_tlast_missing    <= 1'b0;
      err_tuser_mismatch   <= 1'b0;
    end else begin
      err_tlast_unexpected <= (err_tlast_unexpected & ~err_clear) | ev_unexp;
      err_tlast_missing    <= (err_tlast_missing & ~err_clear) | ev_missing;
      err_tuser_mismatch   <= (err_tuser_mismatch & ~err_clear) | ev_tuser;
    end
  end

  // cap_active marks that the current frame began at bin 0 while armed; any frame
  // that ends badly (or is cut by en=0) drops it, so the next bin-0 beat restarts.
  always_ff @(posedge clk) begin
    if (rst) begin
      capture_busy <= 1'b0;
      capture_done <= 1'b0;
      cap_active   <= 1'b0;
    end else if (capture_req && !capture_busy) begin
      capture_busy <= 1'b1;
      capture_done <= 1'b0;
      cap_active   <= 1'b0;
    end else if (capture_busy) begin
      if (state != RUN || !en) begin
        cap_active <= 1'b0;
      end else if (run_beat) begin
        if (frame_end) begin
          cap_active <= 1'b0;
          if (frame_good && cap_active) begin
            capture_busy <= 1'b0;
            capture_done <= 1'b1;
          end
        end else if (bin == '0) begin
          cap_active <= 1'b1;
        end
      end
    end
  end

  assign cap_we = capture_busy & run_beat & (cap_active | (bin == '0));

  ospfb_sink_frame_ram #(
    .DATA_WID (2*WIDTH),
    .DEPTH    (FFT_LEN),
    .RAM_TYPE (RAM_TYPE)
  ) u_frame_ram (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (cap_we),
    .wr_addr (bin),
    .wr_data (s_axis_tdata),
    .rd_addr (rd_addr),
    .rd_data (rd_data)
  );

`ifdef OSPFB_SINK_ERRCNT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_tlast_unexpected <= '0;
      cnt_tlast_missing    <= '0;
      cnt_tuser_mismatch   <= '0;
    end else begin
      cnt_tlast_unexpected <= errcnt_next(cnt_tlast_unexpected, ev_unexp, err_clear);
      cnt_tlast_missing    <= errcnt_next(cnt_tlast_missing, ev_missing, err_clear);
      cnt_tuser_mismatch   <= errcnt_next(cnt_tuser_mismatch, ev_tuser, err_clear);
    end
  end
`endif

endmodule

// File: doc/ospfb_frame_sink.md
Name: ospfb_frame_sink

Overview:
- Consumer for the OSPFB channelised output stream (tdata, tuser, tlast), single DSP clock domain.
- Aligns to frame boundaries and checks framing against FFT_LEN. Counts good frames and reports sticky errors.
- On request, captures one complete frame into a local buffer for register and host readback.
- Used as the receive end in synthesis tops and as the capture block in hardware tests.

Parameters:
- WIDTH, 16, bits per real/imag component; tdata is 2*WIDTH.
- FFT_LEN, 2048, channels per frame (power of two, >=4).
- TUSER_WID, 8, tuser width; carries the low TUSER_WID bits of the channel index.
- FRAME_CNT_WID, 32, width of the good-frame counter.
- RAM_TYPE, "auto", memory primitive hint for the capture buffer.

Ports:
- clk  in  1  DSP clock.
- rst  in  1  synchronous reset, active-high.
- en  in  1  enable; 0 forces IDLE.
- s_axis_tdata  in  2*WIDTH  channel sample {im,re}.
- s_axis_tuser  in  TUSER_WID  channel index, low bits.
- s_axis_tvalid  in  1  beat valid.
- s_axis_tlast  in  1  last channel of frame.
- s_axis_tready  out  1  sink ready.
- synced  out  1  high in RUN.
- frame_count  out  FRAME_CNT_WID  good frames since reset; wraps.
- err_tlast_unexpected  out  1  sticky.
- err_tlast_missing  out  1  sticky.
- err_tuser_mismatch  out  1  sticky.
- err_clear  in  1  pulse; clears the three sticky flags.
- capture_req  in  1  pulse; arms capture of next full frame.
- capture_busy  out  1  capture armed or in progress.
- capture_done  out  1  buffer holds a complete, error-free frame.
- rd_addr  in  $clog2(FFT_LEN)  buffer read address.
- rd_data  out  2*WIDTH  buffer data; 1-cycle registered latency.

Behaviour:
- Reset state:
  - tready=0, state=IDLE.
  - bin=0, frame_count=0.
  - All flags, capture_busy, capture_done and rd_data = 0.
- Beat = tvalid & tready. tready = (state != IDLE). The sink never backpressures in SYNC or RUN.
- State machine:
  - IDLE -> SYNC when en=1.
  - SYNC: discard beats; a beat with tlast -> RUN, bin=0.
  - RUN: every beat checks and advances bin.
  - Any state -> IDLE whenever en=0. A partial frame is dropped; frame_count is not changed. An active capture re-arms (busy stays 1).
- RUN beat checks:
  - tuser != bin[TUSER_WID-1:0]: set err_tuser_mismatch; counting is unaffected; the frame is not "good".
  - bin==FFT_LEN-1 with tlast: good frame if no error occurred in it; frame_count++; bin=0.
  - bin==FFT_LEN-1 without tlast: set err_tlast_missing; go to SYNC.
  - tlast with bin<FFT_LEN-1: set err_tlast_unexpected; bin=0; stay in RUN; the frame is not counted.
- err_clear in the same cycle as a new error: the set wins.
- Capture:
  - capture_req while not busy: busy=1, done=0. capture_req while busy is ignored.
  - Writing starts at the first RUN beat with bin=0 after arming; address = bin.
  - On a good frame end: done=1, busy=0.
  - Errored frame: the capture restarts on the next frame (busy stays 1).
- Buffer: simple dual-port, read-first; a read of the address being written returns the old data.

Optional Feature:
- OSPFB_SINK_ERRCNT_EN defined:
  - Adds three 16-bit saturating counters as outputs: cnt_tlast_unexpected, cnt_tlast_missing, cnt_tuser_mismatch.
  - Each increments on the same events that set the matching sticky flag.
  - err_clear and rst zero them.
- Undefined: the ports and logic are absent; sticky flags only.

Decomposition:
- alpaca_ospfb_constants_pkg gains:
  - typedef enum sink_state_t {IDLE, SYNC, RUN}.
  - SINK_ERRCNT_WID=16.
- Existing WIDTH and FFT_LEN are reused as parameter defaults.
- One sub-module: ospfb_sink_frame_ram (simple dual-port, registered read, RAM_TYPE passed through).

Test Plan:
- Frame alignment: en=1, then 3 FFT_LEN-beat frames with correct tuser/tlast, first frame entered mid-frame at bin 100 -> synced after first tlast; frame_count=2; no error flags.
- Early tlast: tlast at bin 5 in RUN -> err_tlast_unexpected=1; next full frame counted; frame_count increments by 1.
- Missing tlast: no tlast at bin 2047 -> err_tlast_missing=1, synced=0; resyncs on next tlast.
- tuser mismatch: tuser=0x33 at bin 0x32 -> err_tuser_mismatch=1; that frame is not counted; err_clear pulse clears the flag.
- Capture: capture_req, then a frame with tdata=bin*3 -> capture_done=1; rd_addr=7 gives rd_data=21 one cycle later. A capture_req while busy is ignored.
- Reset and enable mid-frame: rst at bin 1000 -> all outputs are 0 next cycle. en=0 mid-capture -> tready=0, capture_busy stays 1, capture completes after re-sync.
